// File: rtl/mult_booth.sv
// Sequential radix-2 Booth multiplier for MULT/MULTU: one iteration per clock,
// 64-bit product delivered on hi/lo with a one-cycle done pulse.
module mult_booth #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_control,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned MW = WIDTH + 1;          // extended operand width
  localparam int unsigned PW = 2 * WIDTH + 3;      // {acc, multiplier, booth bit}
  localparam int unsigned CW = $clog2(WIDTH + 2);  // holds iteration count MW

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_next;
  logic [MW-1:0]   m, m_next;
  logic [PW-1:0]   p, p_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [WIDTH-1:0] hi_next, lo_next;
  logic            busy_next, done_next;
  logic [MW-1:0]   acc_sum;
  logic [PW-1:0]   p_shift;
  logic            ext_a, ext_b;

  // Booth add/sub on the accumulator followed by the arithmetic right shift
  always_comb begin
    acc_sum = p[PW-1 -: MW];
    case (p[1:0])
      2'b01:   acc_sum = p[PW-1 -: MW] + m;
      2'b10:   acc_sum = p[PW-1 -: MW] - m;
      default: acc_sum = p[PW-1 -: MW];
    endcase
    p_shift = {acc_sum[MW-1], acc_sum, p[PW-MW-1:1]};
  end

  assign ext_a = signed_op & A[WIDTH-1];
  assign ext_b = signed_op & B[WIDTH-1];

  // Next-state and datapath update
  always_comb begin
    state_next = state;
    m_next     = m;
    p_next     = p;
    cnt_next   = cnt;
    hi_next    = hi;
    lo_next    = lo;
    busy_next  = busy;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (mult_control) begin
          m_next     = {ext_a, A};
          p_next     = {MW'(0), ext_b, B, 1'b0};
          cnt_next   = CW'(MW);
          busy_next  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        p_next   = p_shift;
        cnt_next = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          hi_next    = p_shift[2*WIDTH:WIDTH+1];
          lo_next    = p_shift[WIDTH:1];
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m    <= '0;
      p    <= '0;
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      m    <= m_next;
      p    <= p_next;
      cnt  <= cnt_next;
      hi   <= hi_next;
      lo   <= lo_next;
      busy <= busy_next;
      done <= done_next;
    end
  end

endmodule

// File: tb/tb_mult_booth.sv
// Directed bench for mult_booth: products, cycle timing, ignored restarts,
// mid-operation reset and back-to-back starts.
module tb_mult_booth;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_control;
  logic        signed_op;
  logic [31:0] A, B;
  logic [31:0] hi, lo;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  mult_booth #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .mult_control(mult_control), .signed_op(signed_op),
    .A(A), .B(B), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Waits on negedges for done; lat = edges after start, -1 on timeout
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    A = a; B = b; signed_op = s; mult_control = 1'b1;
    @(negedge clk);
    mult_control = 1'b0;
    A = $urandom; B = $urandom; signed_op = ~s;
  endtask

  task automatic run_case(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    start_op(a, b, s);
    wait_done(lat);
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL %s latency: got %0d expected 33", name, lat);
    end
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL %s product: got %h_%h expected %h_%h", name, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; mult_control = 1'b0; signed_op = 1'b0; A = '0; B = '0;
    #12;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b expected all zero", hi, lo, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_signed;
    run_case("signed_7x-3", 32'd7, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_case("signed_min_sq", 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000);
    run_case("signed_min_x1", 32'h80000000, 32'd1, 1'b1, 32'hFFFFFFFF, 32'h80000000);
    run_case("signed_m1_sq", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001);
    run_case("signed_zero", 32'h0, 32'h80000000, 1'b1, 32'h00000000, 32'h00000000);
  endtask

  task automatic test_unsigned;
    run_case("unsigned_max_sq", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
    run_case("unsigned_top_x2", 32'h80000000, 32'd2, 1'b0, 32'h00000001, 32'h00000000);
  endtask

  // Cycle-exact busy/done with an ignored restart at edge k+5
  task automatic test_timing;
    logic [31:0] prev_hi, prev_lo;
    prev_hi = hi; prev_lo = lo;
    start_op(32'h12345678, 32'h10, 1'b0);
    for (int n = 1; n <= 34; n++) begin
      if (n == 5) begin
        mult_control = 1'b1; A = 32'h0; B = 32'h0;
      end else begin
        mult_control = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (busy !== (n <= 32) || done !== (n == 33)) begin
        errors++;
        $display("FAIL timing_n%0d: got busy=%b done=%b expected busy=%b done=%b",
                 n, busy, done, (n <= 32), (n == 33));
      end
      if (n == 20) begin
        checks++;
        if (hi !== prev_hi || lo !== prev_lo) begin
          errors++;
          $display("FAIL timing_hold: got %h_%h expected %h_%h", hi, lo, prev_hi, prev_lo);
        end
      end
      if (n == 33) begin
        checks++;
        if (hi !== 32'h00000001 || lo !== 32'h23456780) begin
          errors++;
          $display("FAIL timing_product: got %h_%h expected 00000001_23456780", hi, lo);
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    start_op(32'd5, 32'd6, 1'b0);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got hi=%h lo=%h busy=%b done=%b expected all zero", hi, lo, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 36; n++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_quiet_n%0d: got busy=%b done=%b expected 0 0", n, busy, done);
      end
      if (n == 0) break;
    end
    run_case("after_reset_5x6", 32'd5, 32'd6, 1'b0, 32'h0, 32'd30);
  endtask

  task automatic test_back_to_back;
    int lat;
    start_op(32'd2, 32'd3, 1'b1);
    wait_done(lat);
    checks++;
    if (lat !== 33 || hi !== 32'h0 || lo !== 32'd6) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d %h_%h expected 33 00000000_00000006", lat, hi, lo);
    end
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || hi !== 32'h0 || lo !== 32'd6) begin
      errors++;
      $display("FAIL b2b_restart: got done=%b busy=%b %h_%h expected 0 1 00000000_00000006",
               done, busy, hi, lo);
    end
    repeat (16) @(negedge clk);
    checks++;
    if (hi !== 32'h0 || lo !== 32'd6) begin
      errors++;
      $display("FAIL b2b_hold: got %h_%h expected 00000000_00000006", hi, lo);
    end
    wait_done(lat);
    checks++;
    if (lat !== 17 || hi !== 32'h0 || lo !== 32'd1) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d %h_%h expected 17 00000000_00000001", lat, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_timing();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
